regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the register file's single write port (destination address, write data, write enable) among three requesters: ALU writeback, memory-load return and the debug/host port. It arbitrates round-robin, drives registered write signals into the register file, rejects writes to constant/hard-wired locations with an error report, and supports an exclusive debug lock for multi-register host bursts. It sits between the datapath writeback sources and the register file, under the control unit's `hold`.

## Interface
- `WIDTH`, 16: data width of the register file.
- `ERRW`, 8: width of the saturating error counter.

- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `hold`  in  1  control-unit freeze; no grants while high.
- `alu_valid` / `mem_valid` / `dbg_valid`  in  1 each  write request.
- `alu_ready` / `mem_ready` / `dbg_ready`  out  1 each  request accepted this cycle.
- `alu_addr` / `mem_addr` / `dbg_addr`  in  4 each  destination register.
- `alu_data` / `mem_data` / `dbg_data`  in  WIDTH each  write data.
- `dbg_lock`  in  1  debug requests exclusive port ownership.
- `rf_addrD`  out  4  register-file write address (registered).
- `rf_data`  out  WIDTH  register-file write data (registered).
- `rf_rw`  out  1  register-file write enable (registered).
- `wr_err`  out  1  one-cycle pulse: rejected write.
- `err_addr`  out  4  address of most recent rejected write.
- `err_count`  out  ERRW  rejected writes, saturating at all-ones.
- `locked`  out  1  high in LOCKED state.

## Operation
- Requester indices: ALU=0, MEM=1, DBG=2. Round-robin pointer `ptr` names the highest-priority index; search order ptr, ptr+1, ptr+2 (mod 3).
- Grant is combinational from valids, `ptr`, state and `hold`; at most one `*_ready` high per cycle. `ready` never depends on `ready`; it may depend on `valid`.
- Transfer = `valid & ready`. On transfer from index k: `ptr <= (k+1) mod 3`. No transfer: `ptr` unchanged.
- Writable addresses: 1–8, D, E, F. Protected: 0, 9, A, B, C.
- Transfer to writable address: next edge `rf_rw<=1`, `rf_addrD<=addr`, `rf_data<=data`.
- Transfer to protected address: accepted (ready high), `rf_rw<=0`, `wr_err<=1`, `err_addr<=addr`, `err_count` increments unless saturated.
- No transfer: `rf_rw<=0`, `wr_err<=0`; `rf_addrD`/`rf_data` hold previous values.
- FSM states NORMAL, LOCKED:
  - NORMAL→LOCKED: DBG transfer with `dbg_lock=1`.
  - LOCKED: only DBG may be granted; ALU/MEM ready held low regardless of `ptr`.
  - LOCKED→NORMAL: `dbg_lock=0` sampled at any edge (transfer or not). `ptr` set to 0 on exit.
- `hold=1`: all readys low, `rf_rw<=0`; state, `ptr`, error state retained; `dbg_lock` deassertion still exits LOCKED.

## Timing
- Reset (async, `reset=0`): `rf_rw=0`, `rf_addrD=0`, `rf_data=0`, `wr_err=0`, `err_addr=0`, `err_count=0`, `locked=0`, state NORMAL, `ptr=0`; all readys 0 while reset asserted.
- Latency: transfer in cycle n → `rf_rw` high in cycle n+1 → register file written at edge ending n+1.
- Throughput: one write per cycle; back-to-back transfers yield consecutive `rf_rw` pulses.
- Reset mid-burst: pending registered write dropped (`rf_rw` forced 0 immediately); lock released.
- Requester must hold `valid`, `addr`, `data` stable until transfer.

## Configuration
- `REGFILE_ARB_FIXED_PRIO_EN` defined: fixed priority MEM > ALU > DBG; `ptr` unused (reads 0). LOCKED behaviour unchanged.
- Undefined (default): round-robin as above.

## Test plan
- Reset, then ALU writes addr 3 data 0x1234 → `alu_ready` same cycle, next cycle `rf_rw=1`, `rf_addrD=3`, `rf_data=0x1234`.
- All three valid continuously for 6 cycles from `ptr=0` → grants ALU, MEM, DBG, ALU, MEM, DBG; six consecutive `rf_rw` pulses.
- MEM writes addr 9 data 0xBEEF → `mem_ready=1`, next cycle `rf_rw=0`, `wr_err=1`, `err_addr=9`, `err_count=1`; 300 protected writes with ERRW=8 → `err_count=0xFF`.
- DBG transfer with `dbg_lock=1`, ALU valid for 4 cycles → `locked=1`, `alu_ready=0` throughout; drop `dbg_lock` → `locked=0` next edge, ALU granted following cycle.
- `hold=1` with all valids high for 3 cycles → no readys, `rf_rw=0`; release → normal grant from retained `ptr`.
- Assert `reset=0` asynchronously the cycle after a transfer → `rf_rw` goes 0 without waiting for clock, `locked=0`, `err_count=0`.

Source files
------------

// File: rtl/regfile_write_arbiter_if.sv
// Requester-side bundle for the register-file write arbiter: ALU, MEM and DBG
// write requests plus the debug lock request.
`timescale 1ns/1ps
interface regfile_write_arbiter_if #(
    parameter int WIDTH = 16
);
    logic             alu_valid;
    logic             mem_valid;
    logic             dbg_valid;
    logic             alu_ready;
    logic             mem_ready;
    logic             dbg_ready;
    logic [3:0]       alu_addr;
    logic [3:0]       mem_addr;
    logic [3:0]       dbg_addr;
    logic [WIDTH-1:0] alu_data;
    logic [WIDTH-1:0] mem_data;
    logic [WIDTH-1:0] dbg_data;
    logic             dbg_lock;

    modport master (
        output alu_valid, mem_valid, dbg_valid,
        output alu_addr, mem_addr, dbg_addr,
        output alu_data, mem_data, dbg_data,
        output dbg_lock,
        input  alu_ready, mem_ready, dbg_ready
    );

    modport slave (
        input  alu_valid, mem_valid, dbg_valid,
        input  alu_addr, mem_addr, dbg_addr,
        input  alu_data, mem_data, dbg_data,
        input  dbg_lock,
        output alu_ready, mem_ready, dbg_ready
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the register file's single write port, with protected-address
// rejection and an exclusive debug lock. Define REGFILE_ARB_FIXED_PRIO_EN for fixed MEM > ALU > DBG priority.
`timescale 1ns/1ps
module regfile_write_arbiter #(
    parameter int WIDTH = 16,
    parameter int ERRW  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    hold,
    regfile_write_arbiter_if.slave  req,
    output logic [3:0]              rf_addrD,
    output logic [WIDTH-1:0]        rf_data,
    output logic                    rf_rw,
    output logic                    wr_err,
    output logic [3:0]              err_addr,
    output logic [ERRW-1:0]         err_count,
    output logic                    locked
);

    typedef enum logic {
        NORMAL = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state;
    logic [1:0]       ptr;
    logic [2:0]       valid;
    logic [2:0]       grant;
    logic             xfer;
    logic [1:0]       ptr_next;
    logic [3:0]       sel_addr;
    logic [WIDTH-1:0] sel_data;
    logic             sel_writable;

    assign valid = {req.dbg_valid, req.mem_valid, req.alu_valid};

    // Grant is purely a function of valids, ptr, state, hold and reset; never of ready.
    always_comb begin
        grant = 3'b000;
        if (reset && !hold) begin
            if (state == LOCKED) begin
                grant[2] = valid[2];
            end else begin
`ifdef REGFILE_ARB_FIXED_PRIO_EN
                if (valid[1])      grant = 3'b010;
                else if (valid[0]) grant = 3'b001;
                else if (valid[2]) grant = 3'b100;
`else
                case (ptr)
                    2'd1: begin
                        if (valid[1])      grant = 3'b010;
                        else if (valid[2]) grant = 3'b100;
                        else if (valid[0]) grant = 3'b001;
                    end
                    2'd2: begin
                        if (valid[2])      grant = 3'b100;
                        else if (valid[0]) grant = 3'b001;
                        else if (valid[1]) grant = 3'b010;
                    end
                    default: begin
                        if (valid[0])      grant = 3'b001;
                        else if (valid[1]) grant = 3'b010;
                        else if (valid[2]) grant = 3'b100;
                    end
                endcase
`endif
            end
        end
    end

    assign req.alu_ready = grant[0];
    assign req.mem_ready = grant[1];
    assign req.dbg_ready = grant[2];
    assign xfer          = |grant;

    always_comb begin
        sel_addr = req.alu_addr;
        sel_data = req.alu_data;
        ptr_next = 2'd1;
        if (grant[1]) begin
            sel_addr = req.mem_addr;
            sel_data = req.mem_data;
            ptr_next = 2'd2;
        end else if (grant[2]) begin
            sel_addr = req.dbg_addr;
            sel_data = req.dbg_data;
            ptr_next = 2'd0;
        end
    end

    // Address 0 and 9..C are hard-wired locations that must never be overwritten.
    assign sel_writable = !((sel_addr == 4'h0) || ((sel_addr >= 4'h9) && (sel_addr <= 4'hC)));

    assign locked = (state == LOCKED);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= NORMAL;
            ptr       <= 2'd0;
            rf_rw     <= 1'b0;
            rf_addrD  <= 4'h0;
            rf_data   <= '0;
            wr_err    <= 1'b0;
            err_addr  <= 4'h0;
            err_count <= '0;
        end else begin
            rf_rw  <= 1'b0;
            wr_err <= 1'b0;
            if (xfer) begin
`ifndef REGFILE_ARB_FIXED_PRIO_EN
                ptr <= ptr_next;
`endif
                if (sel_writable) begin
                    rf_rw    <= 1'b1;
                    rf_addrD <= sel_addr;
                    rf_data  <= sel_data;
                end else begin
                    wr_err   <= 1'b1;
                    err_addr <= sel_addr;
                    if (err_count != {ERRW{1'b1}})
                        err_count <= err_count + ERRW'(1);
                end
            end
            // Lock release is honoured even under hold; the pointer restarts at ALU on exit.
            case (state)
                NORMAL: if (grant[2] && req.dbg_lock) state <= LOCKED;
                LOCKED: begin
                    if (!req.dbg_lock) begin
                        state <= NORMAL;
                        ptr   <= 2'd0;
                    end
                end
                default: state <= NORMAL;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: directed scenarios then randomized traffic,
// each cycle predicted by an abstract arbitration model and checked by a separate monitor.
`timescale 1ns/1ps
module tb_regfile_write_arbiter;

    localparam int WIDTH   = 16;
    localparam int ERRW    = 8;
    localparam int ERR_MAX = (1 << ERRW) - 1;

    logic             clk   = 1'b0;
    logic             reset = 1'b1;
    logic             hold;
    logic [3:0]       rf_addrD;
    logic [WIDTH-1:0] rf_data;
    logic             rf_rw;
    logic             wr_err;
    logic [3:0]       err_addr;
    logic [ERRW-1:0]  err_count;
    logic             locked;

    regfile_write_arbiter_if #(.WIDTH(WIDTH)) bus ();

    regfile_write_arbiter #(.WIDTH(WIDTH), .ERRW(ERRW)) dut (
        .clk       (clk),
        .reset     (reset),
        .hold      (hold),
        .req       (bus),
        .rf_addrD  (rf_addrD),
        .rf_data   (rf_data),
        .rf_rw     (rf_rw),
        .wr_err    (wr_err),
        .err_addr  (err_addr),
        .err_count (err_count),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]       ready;
        logic             rw;
        logic [3:0]       addr;
        logic [WIDTH-1:0] data;
        logic             werr;
        logic [3:0]       eaddr;
        int               ecount;
        logic             lck;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    bit               req_valid [3];
    logic [3:0]       req_addr  [3];
    logic [WIDTH-1:0] req_data  [3];
    bit               lock_val;
    bit               hold_val;
    int               last_pick;

    int               m_ptr;
    bit               m_locked;
    bit               m_rw;
    logic [3:0]       m_addr;
    logic [WIDTH-1:0] m_data;
    bit               m_werr;
    logic [3:0]       m_eaddr;
    int               m_ecount;
    int               protected_list [5] = '{0, 9, 10, 11, 12};

    task automatic check_field(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic check_output(input exp_t e);
        check_field("ready", 32'({bus.dbg_ready, bus.mem_ready, bus.alu_ready}), 32'(e.ready));
        check_field("rf_rw", 32'(rf_rw), 32'(e.rw));
        check_field("rf_addrD", 32'(rf_addrD), 32'(e.addr));
        check_field("rf_data", 32'(rf_data), 32'(e.data));
        check_field("wr_err", 32'(wr_err), 32'(e.werr));
        check_field("err_addr", 32'(err_addr), 32'(e.eaddr));
        check_field("err_count", 32'(err_count), 32'(e.ecount));
        check_field("locked", 32'(locked), 32'(e.lck));
    endtask

    function automatic bit is_protected(input logic [3:0] a);
        foreach (protected_list[i])
            if (int'(a) == protected_list[i]) return 1'b1;
        return 1'b0;
    endfunction

    // Reference arbitration: walk the priority order and take the first pending requester.
    function automatic int model_pick();
        int order [3];
        if (hold_val) return -1;
        if (m_locked) return req_valid[2] ? 2 : -1;
`ifdef REGFILE_ARB_FIXED_PRIO_EN
        order = '{1, 0, 2};
`else
        for (int i = 0; i < 3; i++) order[i] = (m_ptr + i) % 3;
`endif
        for (int i = 0; i < 3; i++)
            if (req_valid[order[i]]) return order[i];
        return -1;
    endfunction

    task automatic model_update(input int k);
        m_rw   = 1'b0;
        m_werr = 1'b0;
        if (k >= 0) begin
`ifndef REGFILE_ARB_FIXED_PRIO_EN
            m_ptr = (k + 1) % 3;
`endif
            if (is_protected(req_addr[k])) begin
                m_werr  = 1'b1;
                m_eaddr = req_addr[k];
                if (m_ecount < ERR_MAX) m_ecount++;
            end else begin
                m_rw   = 1'b1;
                m_addr = req_addr[k];
                m_data = req_data[k];
            end
        end
        if (!m_locked) begin
            if (k == 2 && lock_val) m_locked = 1'b1;
        end else if (!lock_val) begin
            m_locked = 1'b0;
            m_ptr    = 0;
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_locked = 0; m_rw = 0; m_addr = '0; m_data = '0;
        m_werr = 0; m_eaddr = '0; m_ecount = 0;
    endtask

    task automatic drive_bus();
        bus.alu_valid = req_valid[0];
        bus.mem_valid = req_valid[1];
        bus.dbg_valid = req_valid[2];
        bus.alu_addr  = req_addr[0];
        bus.mem_addr  = req_addr[1];
        bus.dbg_addr  = req_addr[2];
        bus.alu_data  = req_data[0];
        bus.mem_data  = req_data[1];
        bus.dbg_data  = req_data[2];
        bus.dbg_lock  = lock_val;
        hold          = hold_val;
    endtask

    task automatic set_req(input int i, input bit v, input logic [3:0] a, input logic [WIDTH-1:0] d);
        req_valid[i] = v;
        req_addr[i]  = a;
        req_data[i]  = d;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < 3; i++) set_req(i, 1'b0, 4'h0, '0);
    endtask

    // One cycle: drive after the edge, predict this cycle's grant and visible registers, advance model.
    task automatic apply_stimulus();
        exp_t e;
        int   k;
        @(posedge clk);
        #1;
        drive_bus();
        k        = model_pick();
        e.ready  = (k >= 0) ? 3'(1 << k) : 3'b000;
        e.rw     = m_rw;
        e.addr   = m_addr;
        e.data   = m_data;
        e.werr   = m_werr;
        e.eaddr  = m_eaddr;
        e.ecount = m_ecount;
        e.lck    = m_locked;
        exp_q.push_back(e);
        model_update(k);
        last_pick = k;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_reqs();
        hold_val = 1'b0;
        lock_val = 1'b0;
        drive_bus();
        #1;
        check_field("reset_ready", 32'({bus.dbg_ready, bus.mem_ready, bus.alu_ready}), 32'd0);
        check_field("reset_rf_rw", 32'(rf_rw), 32'd0);
        check_field("reset_rf_addrD", 32'(rf_addrD), 32'd0);
        check_field("reset_rf_data", 32'(rf_data), 32'd0);
        check_field("reset_wr_err", 32'(wr_err), 32'd0);
        check_field("reset_err_addr", 32'(err_addr), 32'd0);
        check_field("reset_err_count", 32'(err_count), 32'd0);
        check_field("reset_locked", 32'(locked), 32'd0);
        model_reset();
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output(e);
            end
        end
    end

    initial begin
        #2;
        do_reset();

        set_req(0, 1'b1, 4'h3, 16'h1234);
        apply_stimulus();
        clear_reqs();
        repeat (2) apply_stimulus();

        // Contention with pointer restarted at ALU.
        do_reset();
        set_req(0, 1'b1, 4'h1, 16'hA001);
        set_req(1, 1'b1, 4'h2, 16'hB002);
        set_req(2, 1'b1, 4'hD, 16'hC003);
        repeat (6) apply_stimulus();
        clear_reqs();
        repeat (2) apply_stimulus();

        set_req(1, 1'b1, 4'h9, 16'hBEEF);
        apply_stimulus();
        clear_reqs();
        apply_stimulus();
        set_req(0, 1'b1, 4'h0, 16'h5555);
        repeat (300) apply_stimulus();
        clear_reqs();
        repeat (2) apply_stimulus();

        set_req(2, 1'b1, 4'h4, 16'h0D0D);
        lock_val = 1'b1;
        apply_stimulus();
        clear_reqs();
        set_req(0, 1'b1, 4'h5, 16'h7777);
        repeat (4) apply_stimulus();
        lock_val = 1'b0;
        repeat (2) apply_stimulus();
        clear_reqs();
        apply_stimulus();

        hold_val = 1'b1;
        set_req(0, 1'b1, 4'h6, 16'h1111);
        set_req(1, 1'b1, 4'h7, 16'h2222);
        set_req(2, 1'b1, 4'h8, 16'h3333);
        repeat (3) apply_stimulus();
        hold_val = 1'b0;
        repeat (3) apply_stimulus();
        clear_reqs();
        apply_stimulus();

        // Reset dropped mid-cycle while a write is pending and the lock is held.
        set_req(2, 1'b1, 4'h6, 16'h6666);
        lock_val = 1'b1;
        apply_stimulus();
        @(posedge clk);
        #1;
        clear_reqs();
        drive_bus();
        check_field("pre_reset_rf_rw", 32'(rf_rw), 32'd1);
        check_field("pre_reset_locked", 32'(locked), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_field("async_rf_rw", 32'(rf_rw), 32'd0);
        check_field("async_locked", 32'(locked), 32'd0);
        check_field("async_err_count", 32'(err_count), 32'd0);
        check_field("async_ready", 32'({bus.dbg_ready, bus.mem_ready, bus.alu_ready}), 32'd0);
        do_reset();

        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (!req_valid[i]) begin
                    req_valid[i] = ($urandom_range(0, 9) < 6);
                    req_addr[i]  = 4'($urandom_range(0, 15));
                    req_data[i]  = WIDTH'($urandom);
                end
            end
            hold_val = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 4) == 0) lock_val = ~lock_val;
            apply_stimulus();
            if (last_pick >= 0) req_valid[last_pick] = 1'b0;
        end
        clear_reqs();
        lock_val = 1'b0;
        hold_val = 1'b0;
        repeat (3) apply_stimulus();
        repeat (2) @(negedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
